mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage: consumes the EX/MEM register outputs, performs the data-bus access for
//  loads/stores via a req/ack handshake, aligns and extends load data, and registers results into
//  the MEM/WB boundary. Raises stallreq while a bus transaction is outstanding, freezing upstream.
// PARAMETERS
//  ADDR_W   32  data-bus address width
//  DATA_W   32  data-bus / register data width (byte lanes = DATA_W/8; only 32 is supported)
// PORTS
//  clk         in   1      pipeline clock
//  rst         in   1      one clock; reset is asynchronous and active-low
//  mem_pc      in   32     PC of the instruction in MEM
//  mem_aluop   in   AluOp  operation code (ALU_LB/LBU/LH/LHU/LW/SB/SH/SW = memory ops)
//  mem_alures  in   32     ALU result; effective address for memory ops
//  mem_wdata   in   32     store data (rt value)
//  mem_wraddr  in   5      destination register
//  mem_wreg    in   1      register write enable
//  dbus_en     out  1      bus request, held until ack
//  dbus_wen    out  4      byte-lane write strobes (0 = read)
//  dbus_addr   out  32     word-aligned address ({alures[31:2],2'b00})
//  dbus_wdata  out  32     store data replicated onto lanes
//  dbus_rdata  in   32     read data, valid with ack
//  dbus_ack    in   1      transaction complete (same cycle as request allowed)
//  stallreq    out  1      =1 while memory op pending and no ack this cycle
//  wb_pc       out  32     registered PC to WB
//  wb_wdata    out  32     registered write-back data
//  wb_wraddr   out  5      registered destination register
//  wb_wreg     out  1      registered write enable
//  exc_addr    out  1      (MEM_ALIGN_CHK_EN only) misaligned-access pulse
//  badvaddr    out  32     (MEM_ALIGN_CHK_EN only) offending address
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE, wb_pc/wb_wdata/badvaddr=ZeroWord, wb_wraddr=ZeroReg, wb_wreg=0,
//    exc_addr=0; dbus_en/stallreq drop immediately (combinational on state/reset). Reset mid-access
//    abandons the transaction; a later stray ack in IDLE with no memory op is ignored.
//  - FSM: IDLE, WAIT. IDLE+memop: dbus_en=1; ack same cycle -> complete, stay IDLE; else -> WAIT.
//    WAIT: dbus_en=1, addr/wen/wdata held stable from mem_* (upstream frozen by stallreq); ack -> IDLE.
//  - stallreq = memop & ~dbus_ack (either state). Upstream regs hold while stallreq=1.
//  - Non-memory op: 1-cycle latency, wb_wdata<=mem_alures, wb_wreg<=mem_wreg. No bus activity.
//  - While stallreq=1, WB sees a bubble: wb_wreg<=0 each edge; on completing edge real values load.
//  - Strobes by addr[1:0]: SB -> 0001<<a; SH -> 0011<<(a[1]*2); SW -> 1111. wdata: SB {4{b}},
//    SH {2{h}}, SW word. Loads: wen=0000.
//  - Load extract: byte lane a[1:0], half lane a[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
//    Stores: wb_wreg<=0 regardless of mem_wreg.
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined: LH/LHU/SH with a[0]=1, LW/SW with a[1:0]!=0 -> no bus request, no
//    stall, wb_wreg<=0, exc_addr<=1 for one cycle, badvaddr<=mem_alures.
//  Undefined: exc_addr/badvaddr ports absent; misaligned low bits ignored (half uses a[1], word 00).
// STRUCTURE
//  Shared defines package: AluOp width, ALU_* opcodes, ZeroWord, ZeroReg, true/false, state codes.
//  Sub-module mem_load_ext: combinational lane select + sign/zero extension (aluop, a[1:0], rdata).
// TESTING
//  1. ADDU result 0x1234, wreg=1, wraddr=5 -> next edge wb_wdata=0x1234, wb_wreg=1, no dbus_en.
//  2. LB addr 0x103, rdata 0x80FF_0000, ack same cycle -> wb_wdata=0xFFFF_FF80, stallreq never 1.
//  3. LHU addr 0x102, ack after 3 cycles, rdata 0xBEEF_0000 -> stallreq=1 x3, wb_wreg=0 x3,
//     then wb_wdata=0x0000_BEEF, addr=0x100 stable throughout.
//  4. SB addr 0x201 data 0xAB -> dbus_wen=0010, dbus_wdata=0xABABABAB; SH 0x202 -> 1100; wb_wreg=0.
//  5. LW pending in WAIT, rst pulsed low -> dbus_en=0 at once, wb_*=0, IDLE; late ack ignored.
//  6. MEM_ALIGN_CHK_EN: LW 0x301 -> exc_addr=1 one cycle, badvaddr=0x301, no dbus_en;
//     undefined: same op reads 0x300.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared opcodes, constants and state codes for the MEM stage.
// Opcode helpers classify memory operations for the stage and its load extender.
package mem_stage_pkg;
    localparam int ALUOP_W = 8;
    localparam logic [ALUOP_W-1:0] ALU_NOP  = 8'h00;
    localparam logic [ALUOP_W-1:0] ALU_ADDU = 8'h01;
    localparam logic [ALUOP_W-1:0] ALU_LB   = 8'h10;
    localparam logic [ALUOP_W-1:0] ALU_LBU  = 8'h11;
    localparam logic [ALUOP_W-1:0] ALU_LH   = 8'h12;
    localparam logic [ALUOP_W-1:0] ALU_LHU  = 8'h13;
    localparam logic [ALUOP_W-1:0] ALU_LW   = 8'h14;
    localparam logic [ALUOP_W-1:0] ALU_SB   = 8'h18;
    localparam logic [ALUOP_W-1:0] ALU_SH   = 8'h19;
    localparam logic [ALUOP_W-1:0] ALU_SW   = 8'h1a;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic [4:0]  ZERO_REG  = 5'h0;
    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;
    typedef enum logic {IDLE, WAIT} state_e;
    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return op == ALU_LB || op == ALU_LBU || op == ALU_LH || op == ALU_LHU || op == ALU_LW;
    endfunction
    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return op == ALU_SB || op == ALU_SH || op == ALU_SW;
    endfunction
endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: selects the byte/half lane of the read word and sign/zero extends it.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [31:0]        rdata_i,
    output logic [31:0]        data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b      = rdata_i[{addr_lo_i, 3'b000} +: 8];
        h      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = aluop_i == ALU_LB  ? {{24{b[7]}}, b} :
                 aluop_i == ALU_LBU ? {24'h0, b} :
                 aluop_i == ALU_LH  ? {{16{h[15]}}, h} :
                 aluop_i == ALU_LHU ? {16'h0, h} : rdata_i;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with req/ack data bus and MEM/WB register.
// Define MEM_ALIGN_CHK_EN to trap misaligned half/word accesses via exc_addr_o/badvaddr_o.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [31:0]        mem_pc_i,
    input  logic [ALUOP_W-1:0] mem_aluop_i,
    input  logic [31:0]        mem_alures_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic [4:0]         mem_wraddr_i,
    input  logic               mem_wreg_i,
    output logic               dbus_en_o,
    output logic [3:0]         dbus_wen_o,
    output logic [ADDR_W-1:0]  dbus_addr_o,
    output logic [DATA_W-1:0]  dbus_wdata_o,
    input  logic [DATA_W-1:0]  dbus_rdata_i,
    input  logic               dbus_ack_i,
    output logic               stallreq_o,
`ifdef MEM_ALIGN_CHK_EN
    output logic               exc_addr_o,
    output logic [31:0]        badvaddr_o,
`endif
    output logic [31:0]        wb_pc_o,
    output logic [31:0]        wb_wdata_o,
    output logic [4:0]         wb_wraddr_o,
    output logic               wb_wreg_o
);
    state_e      state_q, state_d;
    logic        load, store, misalign, go;
    logic [1:0]  a;
    logic [31:0] load_data;
    logic [31:0] wb_pc_q, wb_pc_d, wb_wdata_q, wb_wdata_d;
    logic [4:0]  wb_wraddr_q, wb_wraddr_d;
    logic        wb_wreg_q, wb_wreg_d;

    assign a     = mem_alures_i[1:0];
    assign load  = is_load(mem_aluop_i);
    assign store = is_store(mem_aluop_i);
`ifdef MEM_ALIGN_CHK_EN
    assign misalign = ((mem_aluop_i == ALU_LH || mem_aluop_i == ALU_LHU || mem_aluop_i == ALU_SH) && a[0]) ||
                      ((mem_aluop_i == ALU_LW || mem_aluop_i == ALU_SW) && a != 2'b00);
`else
    assign misalign = FALSE;
`endif
    assign go = (load | store) & ~misalign;

    mem_load_ext u_load_ext (
        .aluop_i   (mem_aluop_i),
        .addr_lo_i (a),
        .rdata_i   (dbus_rdata_i),
        .data_o    (load_data)
    );

    // Bus request and stall are gated by reset so an abandoned access drops at once.
    always_comb begin
        dbus_en_o    = rst_ni & (go | state_q == WAIT);
        stallreq_o   = rst_ni & go & ~dbus_ack_i;
        state_d      = (go & ~dbus_ack_i) ? WAIT : IDLE;
        dbus_addr_o  = {mem_alures_i[ADDR_W-1:2], 2'b00};
        dbus_wen_o   = mem_aluop_i == ALU_SB ? 4'b0001 << a :
                       mem_aluop_i == ALU_SH ? 4'b0011 << {a[1], 1'b0} :
                       mem_aluop_i == ALU_SW ? 4'b1111 : 4'b0000;
        dbus_wdata_o = mem_aluop_i == ALU_SB ? {4{mem_wdata_i[7:0]}} :
                       mem_aluop_i == ALU_SH ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
    end

    // A stalled edge inserts a bubble; the completing edge loads the real result.
    always_comb begin
        wb_pc_d     = stallreq_o ? wb_pc_q : mem_pc_i;
        wb_wraddr_d = stallreq_o ? wb_wraddr_q : mem_wraddr_i;
        wb_wdata_d  = stallreq_o ? wb_wdata_q : load ? load_data : mem_alures_i;
        wb_wreg_d   = ~stallreq_o & mem_wreg_i & ~store & ~misalign;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wb_pc_q     <= ZERO_WORD;
            wb_wdata_q  <= ZERO_WORD;
            wb_wraddr_q <= ZERO_REG;
            wb_wreg_q   <= FALSE;
        end else begin
            state_q     <= state_d;
            wb_pc_q     <= wb_pc_d;
            wb_wdata_q  <= wb_wdata_d;
            wb_wraddr_q <= wb_wraddr_d;
            wb_wreg_q   <= wb_wreg_d;
        end
    end

`ifdef MEM_ALIGN_CHK_EN
    logic        exc_q;
    logic [31:0] badvaddr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exc_q      <= FALSE;
            badvaddr_q <= ZERO_WORD;
        end else begin
            exc_q      <= misalign;
            badvaddr_q <= misalign ? mem_alures_i : badvaddr_q;
        end
    end
    assign exc_addr_o = exc_q;
    assign badvaddr_o = badvaddr_q;
`endif

    assign wb_pc_o     = wb_pc_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign wb_wraddr_o = wb_wraddr_q;
    assign wb_wreg_o   = wb_wreg_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage (both MEM_ALIGN_CHK_EN builds).
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  ra;
        logic        we;
        bit          dc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] mem_pc_i, mem_alures_i, mem_wdata_i, dbus_rdata_i;
    logic [7:0]  mem_aluop_i;
    logic [4:0]  mem_wraddr_i;
    logic        mem_wreg_i, dbus_ack_i;
    logic        dbus_en_o, stallreq_o, wb_wreg_o;
    logic [3:0]  dbus_wen_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, wb_pc_o, wb_wdata_o;
    logic [4:0]  wb_wraddr_o;
`ifdef MEM_ALIGN_CHK_EN
    logic        exc_addr_o;
    logic [31:0] badvaddr_o;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    mem_stage dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mem_pc_i     (mem_pc_i),
        .mem_aluop_i  (mem_aluop_i),
        .mem_alures_i (mem_alures_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_wraddr_i (mem_wraddr_i),
        .mem_wreg_i   (mem_wreg_i),
        .dbus_en_o    (dbus_en_o),
        .dbus_wen_o   (dbus_wen_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_rdata_i (dbus_rdata_i),
        .dbus_ack_i   (dbus_ack_i),
        .stallreq_o   (stallreq_o),
`ifdef MEM_ALIGN_CHK_EN
        .exc_addr_o   (exc_addr_o),
        .badvaddr_o   (badvaddr_o),
`endif
        .wb_pc_o      (wb_pc_o),
        .wb_wdata_o   (wb_wdata_o),
        .wb_wraddr_o  (wb_wraddr_o),
        .wb_wreg_o    (wb_wreg_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] ra, input logic we);
        mem_aluop_i  = op;
        mem_pc_i     = pc;
        mem_alures_i = a;
        mem_wdata_i  = wd;
        mem_wraddr_i = ra;
        mem_wreg_i   = we;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] data, input logic [4:0] ra,
                        input logic we, input bit dc);
        exp_t e;
        e.pc = pc; e.data = data; e.ra = ra; e.we = we; e.dc = dc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic retire(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty at retire", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".pc"}, wb_pc_o, e.pc);
            check({tag, ".wraddr"}, {27'h0, wb_wraddr_o}, {27'h0, e.ra});
            check({tag, ".wreg"}, {31'h0, wb_wreg_o}, {31'h0, e.we});
            if (e.dc) check({tag, ".wdata"}, wb_wdata_o, e.data);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        dbus_ack_i = 1'b0;
        dbus_rdata_i = 32'h0;
        drive(ALU_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        #12;
        check("rst.wb_pc", wb_pc_o, 32'h0);
        check("rst.wb_wdata", wb_wdata_o, 32'h0);
        check("rst.wb_wreg", {31'h0, wb_wreg_o}, 32'h0);
        check("rst.dbus_en", {31'h0, dbus_en_o}, 32'h0);
        rst_ni = 1'b1;

        // ALU result passes straight through
        drive(ALU_ADDU, 32'h40, 32'h1234, 32'h0, 5'd5, 1'b1);
        push(32'h40, 32'h1234, 5'd5, 1'b1, 1'b1);
        #1;
        check("addu.dbus_en", {31'h0, dbus_en_o}, 32'h0);
        check("addu.stall", {31'h0, stallreq_o}, 32'h0);
        tick();
        retire("addu");

        // LB with same-cycle ack
        drive(ALU_LB, 32'h44, 32'h103, 32'h0, 5'd6, 1'b1);
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'h80FF_0000;
        push(32'h44, 32'hFFFF_FF80, 5'd6, 1'b1, 1'b1);
        #1;
        check("lb.dbus_en", {31'h0, dbus_en_o}, 32'h1);
        check("lb.stall", {31'h0, stallreq_o}, 32'h0);
        check("lb.addr", dbus_addr_o, 32'h100);
        check("lb.wen", {28'h0, dbus_wen_o}, 32'h0);
        tick();
        retire("lb");

        // LHU acked after three stalled cycles
        drive(ALU_LHU, 32'h48, 32'h102, 32'h0, 5'd7, 1'b1);
        dbus_ack_i = 1'b0;
        dbus_rdata_i = 32'h0;
        push(32'h48, 32'h0000_BEEF, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lhu.stall", {31'h0, stallreq_o}, 32'h1);
            check("lhu.en", {31'h0, dbus_en_o}, 32'h1);
            check("lhu.addr", dbus_addr_o, 32'h100);
            tick();
            check("lhu.bubble", {31'h0, wb_wreg_o}, 32'h0);
        end
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'hBEEF_0000;
        #1;
        check("lhu.stall_ack", {31'h0, stallreq_o}, 32'h0);
        check("lhu.addr_ack", dbus_addr_o, 32'h100);
        tick();
        retire("lhu");

        // more extension cases, all acked at once
        drive(ALU_LH, 32'h4c, 32'h100, 32'h0, 5'd8, 1'b1);
        dbus_rdata_i = 32'h0000_8001;
        push(32'h4c, 32'hFFFF_8001, 5'd8, 1'b1, 1'b1);
        tick();
        retire("lh");
        drive(ALU_LBU, 32'h50, 32'h101, 32'h0, 5'd9, 1'b1);
        dbus_rdata_i = 32'h0000_F000;
        push(32'h50, 32'h0000_00F0, 5'd9, 1'b1, 1'b1);
        tick();
        retire("lbu");
        drive(ALU_LW, 32'h54, 32'h108, 32'h0, 5'd10, 1'b1);
        dbus_rdata_i = 32'hCAFE_F00D;
        push(32'h54, 32'hCAFE_F00D, 5'd10, 1'b1, 1'b1);
        tick();
        retire("lw");

        // stores: strobes, replicated data, no write-back
        drive(ALU_SB, 32'h58, 32'h201, 32'h0000_00AB, 5'd11, 1'b1);
        push(32'h58, 32'h0, 5'd11, 1'b0, 1'b0);
        #1;
        check("sb.wen", {28'h0, dbus_wen_o}, 32'b0010);
        check("sb.wdata", dbus_wdata_o, 32'hABAB_ABAB);
        check("sb.addr", dbus_addr_o, 32'h200);
        tick();
        retire("sb");
        drive(ALU_SH, 32'h5c, 32'h202, 32'h1234_CDEF, 5'd12, 1'b1);
        push(32'h5c, 32'h0, 5'd12, 1'b0, 1'b0);
        #1;
        check("sh.wen", {28'h0, dbus_wen_o}, 32'b1100);
        check("sh.wdata", dbus_wdata_o, 32'hCDEF_CDEF);
        tick();
        retire("sh");
        drive(ALU_SW, 32'h60, 32'h204, 32'hDEAD_BEEF, 5'd13, 1'b1);
        push(32'h60, 32'h0, 5'd13, 1'b0, 1'b0);
        #1;
        check("sw.wen", {28'h0, dbus_wen_o}, 32'b1111);
        check("sw.wdata", dbus_wdata_o, 32'hDEAD_BEEF);
        tick();
        retire("sw");

        // reset in the middle of a pending LW
        dbus_ack_i = 1'b0;
        drive(ALU_LW, 32'h64, 32'h400, 32'h0, 5'd14, 1'b1);
        tick();
        check("rstw.stall", {31'h0, stallreq_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        check("rstw.dbus_en", {31'h0, dbus_en_o}, 32'h0);
        check("rstw.stall0", {31'h0, stallreq_o}, 32'h0);
        check("rstw.wb_pc", wb_pc_o, 32'h0);
        check("rstw.wb_wdata", wb_wdata_o, 32'h0);
        check("rstw.wb_wreg", {31'h0, wb_wreg_o}, 32'h0);
        sb.delete();
        drive(ALU_NOP, 32'h68, 32'h0, 32'h0, 5'd0, 1'b0);
        #2;
        rst_ni = 1'b1;
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'h5555_5555;
        push(32'h68, 32'h0, 5'd0, 1'b0, 1'b1);
        #1;
        check("stray.dbus_en", {31'h0, dbus_en_o}, 32'h0);
        check("stray.stall", {31'h0, stallreq_o}, 32'h0);
        tick();
        retire("stray");
        drive(ALU_LW, 32'h6c, 32'h104, 32'h0, 5'd15, 1'b1);
        dbus_rdata_i = 32'h0BAD_F00D;
        push(32'h6c, 32'h0BAD_F00D, 5'd15, 1'b1, 1'b1);
        #1;
        check("post.stall", {31'h0, stallreq_o}, 32'h0);
        tick();
        retire("post");

        // misaligned LW
        drive(ALU_LW, 32'h70, 32'h301, 32'h0, 5'd16, 1'b1);
        dbus_rdata_i = 32'h1122_3344;
`ifdef MEM_ALIGN_CHK_EN
        push(32'h70, 32'h0, 5'd16, 1'b0, 1'b0);
        #1;
        check("mis.dbus_en", {31'h0, dbus_en_o}, 32'h0);
        check("mis.stall", {31'h0, stallreq_o}, 32'h0);
        tick();
        retire("mis");
        check("mis.exc", {31'h0, exc_addr_o}, 32'h1);
        check("mis.badvaddr", badvaddr_o, 32'h301);
        drive(ALU_NOP, 32'h74, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        check("mis.exc_clr", {31'h0, exc_addr_o}, 32'h0);
        check("mis.badvaddr_hold", badvaddr_o, 32'h301);
`else
        push(32'h70, 32'h1122_3344, 5'd16, 1'b1, 1'b1);
        #1;
        check("mis.dbus_en", {31'h0, dbus_en_o}, 32'h1);
        check("mis.addr", dbus_addr_o, 32'h300);
        tick();
        retire("mis");
`endif
        dbus_ack_i = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
